// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a Moore FSM that steps each instruction
// through fetch, decode and its execution states, driving datapath controls.
// Optional feature: define MULTICYCLE_CTRL_ADDI_EN to add the addi states
// (ADDIEX/ADDIWB); without it Op 001000 decodes as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       WE3,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
`endif
  localparam logic [3:0] JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       funct_ok;
  logic       op_ok;
  logic [2:0] funct_alu;

  // Map the R-type function field to an ALU operation and flag unknown codes
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b000;
    case (Funct)
      FN_ADD:  funct_alu = 3'b010;
      FN_SUB:  funct_alu = 3'b110;
      FN_AND:  funct_alu = 3'b000;
      FN_OR:   funct_alu = 3'b001;
      FN_SLT:  funct_alu = 3'b111;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Decide whether the instruction in the IR is one this unit can execute
  always_comb begin
    op_ok = 1'b0;
    case (Op)
      OP_LW, OP_SW, OP_BEQ, OP_J: op_ok = 1'b1;
      OP_RTYPE:                   op_ok = funct_ok;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      OP_ADDI:                    op_ok = 1'b1;
`else
      OP_ADDI:                    op_ok = 1'b0;
`endif
      default:                    op_ok = 1'b0;
    endcase
  end

  // Next-state selection; illegal instructions and unused codes return to FETCH
  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (op_ok) begin
          case (Op)
            OP_LW, OP_SW: next_state = MEMADR;
            OP_RTYPE:     next_state = EXECUTE;
            OP_BEQ:       next_state = BRANCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
            OP_ADDI:      next_state = ADDIEX;
`endif
            OP_J:         next_state = JUMP;
            default:      next_state = FETCH;
          endcase
        end
      end
      MEMADR:  next_state = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   next_state = MEMWB;
      EXECUTE: next_state = ALUWB;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDIEX:  next_state = ADDIWB;
`endif
      default: next_state = FETCH;
    endcase
  end

  // State register with synchronous active-low reset back to FETCH
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= next_state;
  end

  // Moore output decode; everything is held at zero while reset is low
  always_comb begin
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    IRWrite    = 1'b0;
    WE3        = 1'b0;
    ALUSrcA    = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b000;
    illegal_op = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = 3'b010;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = 3'b010;
          illegal_op = !op_ok;
        end
        MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = 3'b010;
        end
        MEMRD: IorD = 1'b1;
        MEMWB: begin
          MemtoReg = 1'b1;
          WE3      = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA    = 1'b1;
          ALUControl = funct_alu;
        end
        ALUWB: begin
          RegDst = 1'b1;
          WE3    = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = 3'b110;
          PCSrc      = 2'b01;
          Branch     = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_ADDI_EN
        ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = 3'b010;
        end
        ADDIWB: WE3 = 1'b1;
`endif
        JUMP: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = reset ? state_q : FETCH;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction's expected
// state walk and per-state controls come from a table-driven reference model.
module tb_multicycle_control;

  typedef struct packed {
    logic iord, regdst, memtoreg, irwrite, we3, alusrca, branch, pcwrite, memwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluctl;
  } ctrl_t;

`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite, MemWrite;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       illegal_op;
  logic [3:0] state;
  ctrl_t      obs;

  int total = 0;
  int bad = 0;
  int exp_seq[$];
  bit exp_legal;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .WE3(WE3), .ALUSrcA(ALUSrcA), .Branch(Branch), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite,
                MemWrite, ALUSrcB, PCSrc, ALUControl};

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    if (fn == 6'b100000) return 3'b010;
    if (fn == 6'b100010) return 3'b110;
    if (fn == 6'b100100) return 3'b000;
    if (fn == 6'b100101) return 3'b001;
    if (fn == 6'b101010) return 3'b111;
    return 3'b000;
  endfunction

  function automatic bit funct_known(logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Controls expected while sitting in a given state
  function automatic ctrl_t exp_ctrl(int st, logic [5:0] fn);
    ctrl_t c = '0;
    case (st)
      0:  begin c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01; c.aluctl = 3'b010; end
      1:  begin c.alusrcb = 2'b11; c.aluctl = 3'b010; end
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluctl = 3'b010; end
      3:  c.iord = 1;
      4:  begin c.memtoreg = 1; c.we3 = 1; end
      5:  begin c.iord = 1; c.memwrite = 1; end
      6:  begin c.alusrca = 1; c.aluctl = alu_of(fn); end
      7:  begin c.regdst = 1; c.we3 = 1; end
      8:  begin c.alusrca = 1; c.aluctl = 3'b110; c.pcsrc = 2'b01; c.branch = 1; end
      9:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluctl = 3'b010; end
      10: c.we3 = 1;
      11: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction (called while in FETCH) and build its expected state walk
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn);
    Op = op;
    Funct = fn;
    exp_seq.delete();
    exp_legal = 1'b1;
    case (op)
      6'b100011: exp_seq = '{0, 1, 2, 3, 4};
      6'b101011: exp_seq = '{0, 1, 2, 5};
      6'b000100: exp_seq = '{0, 1, 8};
      6'b000010: exp_seq = '{0, 1, 11};
      6'b000000: if (funct_known(fn)) exp_seq = '{0, 1, 6, 7}; else exp_legal = 1'b0;
      6'b001000: if (ADDI_EN) exp_seq = '{0, 1, 9, 10}; else exp_legal = 1'b0;
      default:   exp_legal = 1'b0;
    endcase
    if (!exp_legal) exp_seq = '{0, 1};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++;
    if (obs !== ctrl_t'(0)) begin bad++; $display("FAIL reset_ctrl got=%h want=0", obs); end
    total++;
    if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal_op); end
    reset = 1'b1;
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL release_state got=%0d want=0", state); end
    total++;
    if (obs !== exp_ctrl(0, Funct)) begin bad++; $display("FAIL release_ctrl got=%h want=%h", obs, exp_ctrl(0, Funct)); end
  endtask

  task automatic test_lw_sw();
    logic [5:0] ops[2] = '{6'b100011, 6'b101011};
    foreach (ops[i]) begin
      drive_instr(ops[i], 6'($urandom));
      for (int k = 0; k <= exp_seq.size(); k++) begin
        int want = (k == exp_seq.size()) ? 0 : exp_seq[k];
        total++;
        if (state !== 4'(want)) begin bad++; $display("FAIL memop_state op=%b step=%0d got=%0d want=%0d", Op, k, state, want); end
        total++;
        if (obs !== exp_ctrl(want, Funct)) begin bad++; $display("FAIL memop_ctrl op=%b step=%0d got=%h want=%h", Op, k, obs, exp_ctrl(want, Funct)); end
        total++;
        if (illegal_op !== 1'b0) begin bad++; $display("FAIL memop_illegal step=%0d got=%b want=0", k, illegal_op); end
        if (k < exp_seq.size()) tick();
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5] = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101};
    foreach (fns[i]) begin
      drive_instr(6'b000000, fns[i]);
      for (int k = 0; k <= exp_seq.size(); k++) begin
        int want = (k == exp_seq.size()) ? 0 : exp_seq[k];
        total++;
        if (state !== 4'(want)) begin bad++; $display("FAIL rtype_state fn=%b step=%0d got=%0d want=%0d", Funct, k, state, want); end
        total++;
        if (obs !== exp_ctrl(want, Funct)) begin bad++; $display("FAIL rtype_ctrl fn=%b step=%0d got=%h want=%h", Funct, k, obs, exp_ctrl(want, Funct)); end
        if (k < exp_seq.size()) tick();
      end
    end
  endtask

  task automatic test_beq_j();
    logic [5:0] ops[2] = '{6'b000100, 6'b000010};
    foreach (ops[i]) begin
      drive_instr(ops[i], 6'($urandom));
      for (int k = 0; k <= exp_seq.size(); k++) begin
        int want = (k == exp_seq.size()) ? 0 : exp_seq[k];
        total++;
        if (state !== 4'(want)) begin bad++; $display("FAIL pcop_state op=%b step=%0d got=%0d want=%0d", Op, k, state, want); end
        total++;
        if (obs !== exp_ctrl(want, Funct)) begin bad++; $display("FAIL pcop_ctrl op=%b step=%0d got=%h want=%h", Op, k, obs, exp_ctrl(want, Funct)); end
        if (k < exp_seq.size()) tick();
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[3] = '{6'b111111, 6'b000000, 6'b000000};
    logic [5:0] fns[3] = '{6'b000000, 6'b000000, 6'b111111};
    foreach (ops[i]) begin
      drive_instr(ops[i], fns[i]);
      for (int k = 0; k <= exp_seq.size(); k++) begin
        int want = (k == exp_seq.size()) ? 0 : exp_seq[k];
        total++;
        if (state !== 4'(want)) begin bad++; $display("FAIL illegal_state op=%b fn=%b step=%0d got=%0d want=%0d", Op, Funct, k, state, want); end
        total++;
        if (obs !== exp_ctrl(want, Funct)) begin bad++; $display("FAIL illegal_ctrl step=%0d got=%h want=%h", k, obs, exp_ctrl(want, Funct)); end
        total++;
        if (illegal_op !== (want == 1)) begin bad++; $display("FAIL illegal_pulse step=%0d got=%b want=%b", k, illegal_op, want == 1); end
        if (k < exp_seq.size()) tick();
      end
    end
  endtask

  task automatic test_addi();
    drive_instr(6'b001000, 6'($urandom));
    for (int k = 0; k <= exp_seq.size(); k++) begin
      int want = (k == exp_seq.size()) ? 0 : exp_seq[k];
      total++;
      if (state !== 4'(want)) begin bad++; $display("FAIL addi_state step=%0d got=%0d want=%0d", k, state, want); end
      total++;
      if (obs !== exp_ctrl(want, Funct)) begin bad++; $display("FAIL addi_ctrl step=%0d got=%h want=%h", k, obs, exp_ctrl(want, Funct)); end
      total++;
      if (illegal_op !== (!exp_legal && want == 1)) begin bad++; $display("FAIL addi_illegal step=%0d got=%b want=%b", k, illegal_op, !exp_legal && want == 1); end
      if (k < exp_seq.size()) tick();
    end
  endtask

  task automatic test_reset_mid();
    drive_instr(6'b100011, 6'd0);
    tick();
    tick();
    tick();
    total++;
    if (state !== 4'd3) begin bad++; $display("FAIL mid_pre_state got=%0d want=3", state); end
    reset = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || obs !== ctrl_t'(0) || illegal_op !== 1'b0) begin
      bad++; $display("FAIL mid_assert got state=%0d ctrl=%h ill=%b want 0/0/0", state, obs, illegal_op);
    end
    tick();
    total++;
    if (state !== 4'd0 || obs !== ctrl_t'(0) || illegal_op !== 1'b0) begin
      bad++; $display("FAIL mid_edge got state=%0d ctrl=%h ill=%b want 0/0/0", state, obs, illegal_op);
    end
    reset = 1'b1;
    #1;
    total++;
    if (state !== 4'd0 || obs !== exp_ctrl(0, Funct)) begin
      bad++; $display("FAIL mid_release got state=%0d ctrl=%h want 0/%h", state, obs, exp_ctrl(0, Funct));
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] op, fn;
    for (int n = 0; n < 60; n++) begin
      int pick = int'($urandom_range(0, 7));
      op = (pick < 6) ? pool[pick] : ((pick == 6) ? 6'($urandom) : 6'b000000);
      fn = ($urandom_range(0, 1) == 0) ? 6'($urandom) : alu_fn_pick(int'($urandom_range(0, 4)));
      drive_instr(op, fn);
      for (int k = 0; k <= exp_seq.size(); k++) begin
        int want = (k == exp_seq.size()) ? 0 : exp_seq[k];
        total++;
        if (state !== 4'(want)) begin bad++; $display("FAIL rand_state op=%b fn=%b step=%0d got=%0d want=%0d", Op, Funct, k, state, want); end
        total++;
        if (obs !== exp_ctrl(want, Funct)) begin bad++; $display("FAIL rand_ctrl op=%b fn=%b step=%0d got=%h want=%h", Op, Funct, k, obs, exp_ctrl(want, Funct)); end
        total++;
        if (illegal_op !== (!exp_legal && want == 1)) begin bad++; $display("FAIL rand_illegal op=%b fn=%b step=%0d got=%b", Op, Funct, k, illegal_op); end
        if (k < exp_seq.size()) tick();
      end
    end
  endtask

  function automatic logic [5:0] alu_fn_pick(int i);
    logic [5:0] tbl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return tbl[i];
  endfunction

  initial begin
    test_reset();
    test_lw_sw();
    test_rtype();
    test_beq_j();
    test_illegal();
    test_addi();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
